k2_mem_arbiter: RTL and testbench
=================================

// Module: k2_mem_arbiter
// PURPOSE
//  Two-port arbiter sharing the K2 single-port data RAM between the CPU core and a
//  host/loader port (program debug, data preload). Arbitrates per cycle, drives the
//  RAM address/write/data lines from the winner, and returns read data through a
//  registered, one-cycle-pulse response per requester. Sits between K2 core and RAM.
// PARAMETERS
//  AW  4  RAM address width (16 words)
//  DW  8  RAM data width
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset_n      in   1   synchronous, active-low reset
//  core_req     in   1   core transaction request; hold with cmd stable until core_gnt
//  core_we      in   1   1=write, 0=read
//  core_addr    in   AW  core address
//  core_wdata   in   DW  core write data
//  core_gnt     out  1   one-cycle grant; RAM access happens this cycle
//  core_rvalid  out  1   one-cycle pulse, core_rdata valid (reads only)
//  core_rdata   out  DW  registered read data for core
//  host_req/host_we/host_addr/host_wdata/host_gnt/host_rvalid/host_rdata: as core_*
//  mem_we       out  1   RAM write enable
//  mem_addr     out  AW  RAM address
//  mem_wdata    out  DW  RAM write data
//  mem_rdata    in   DW  RAM read data, combinational from mem_addr
//  busy         out  1   1 while a grant is active (state != IDLE)
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state=IDLE, all gnt/rvalid=0, rdata regs=0, last=HOST.
//    Transaction in flight is dropped: no write beyond the edge, no rvalid.
//  - FSM states IDLE, G_CORE, G_HOST; one state per cycle, each grant lasts 1 cycle.
//  - At every edge next state from eligible requests: eligible = req & ~gnt (a port
//    granted this cycle is masked for the next decision; its req still high counts
//    as a new request only one cycle later). None eligible -> IDLE.
//  - Both eligible: core wins (fixed priority; see CONFIGURATION).
//  - Latency: req sampled at edge E -> gnt high cycle after E -> rvalid one cycle later.
//  - Back-to-back: G_CORE->G_HOST->G_CORE... with no idle bubble; RAM 100% utilised.
//  - During G_x: mem_addr=x_addr, mem_wdata=x_wdata, mem_we=x_we; x_gnt=1.
//  - In IDLE: mem_we=0, mem_addr=0, mem_wdata=0 (no spurious writes).
//  - Read: at end of G_x, x_rdata<=mem_rdata; x_rvalid=1 next cycle only.
//    x_rdata holds value until the next read for that port.
//  - Write: RAM captures at end of G_x; no rvalid generated.
//  - Requester dropping req before gnt: request withdrawn, no access, no error.
//  - Write then read same address back-to-back returns the new data.
// CONFIGURATION
//  K2_ARB_ROUND_ROBIN_EN defined: tie (both eligible) goes to the port not granted
//   last; 'last' updated on every grant, HOST after reset so core wins first tie.
//  Undefined: fixed priority, core always wins ties; 'last' unused.
//  Masking rule applies in both modes, so neither port starves.
// TESTING
//  1 mem[3]=8'h5A; core read addr 3 req at cyc0 -> core_gnt cyc1, mem_addr=3,
//    core_rvalid cyc2, core_rdata=8'h5A; host_gnt never high.
//  2 host write addr 7 data 8'hC3 -> cyc1 mem_we=1 mem_addr=7 mem_wdata=8'hC3, no
//    host_rvalid; following core read addr 7 -> core_rdata=8'hC3.
//  3 core and host req held from cyc0 (reads) -> gnt order C,H,C,H on cyc1..4,
//    rvalids one cycle after each gnt, mem_we stays 0.
//  4 RR macro: host-only grant, then both req same cycle -> core granted first;
//    repeat after core-only grant -> host first. Without macro -> core both times.
//  5 reset_n=0 at edge during G_CORE read -> next cyc core_gnt=0, core_rvalid=0,
//    core_rdata=0, busy=0, mem_we=0.
//  6 idle: no req for 10 cycles -> mem_we=0, mem_addr=0, busy=0 throughout.

Source files
------------

// File: rtl/k2_mem_arbiter.sv
// k2_mem_arbiter: shares the K2 single-port data RAM between the CPU core and
// the host/loader port. One grant per cycle, each lasting one cycle. Read data
// returns through a registered, one-cycle rvalid pulse per requester.
// Optional build macro: K2_ARB_ROUND_ROBIN_EN. When it is defined, a tie goes
// to the port not granted last. When it is undefined, the core always wins a tie.
module k2_mem_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    G_CORE = 2'd1,
    G_HOST = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic          core_rvalid_r;
  logic          host_rvalid_r;
  logic [DW-1:0] core_rdata_r;
  logic [DW-1:0] host_rdata_r;
  logic          core_elig_s;
  logic          host_elig_s;
  logic          prefer_core_s;

`ifdef K2_ARB_ROUND_ROBIN_EN
  logic          last_host_r;   // 1 = host was granted most recently
`endif

  // Pick the next owner from the eligible requests; prefer_core breaks ties.
  function automatic state_t next_state_f(input logic ce, input logic he,
                                          input logic prefer_core);
    state_t ns;
    ns = IDLE;
    if (ce && he) begin
      if (prefer_core) ns = G_CORE;
      else             ns = G_HOST;
    end else if (ce) begin
      ns = G_CORE;
    end else if (he) begin
      ns = G_HOST;
    end else begin
      ns = IDLE;
    end
    return ns;
  endfunction

  // Grants and busy decode straight from the state register.
  assign core_gnt    = (state_r == G_CORE);
  assign host_gnt    = (state_r == G_HOST);
  assign busy        = (state_r != IDLE);
  assign core_rvalid = core_rvalid_r;
  assign host_rvalid = host_rvalid_r;
  assign core_rdata  = core_rdata_r;
  assign host_rdata  = host_rdata_r;

  // A port served in this cycle sits out the next decision, so the other
  // port always gets a turn and neither can starve.
  assign core_elig_s = core_req & ~core_gnt;
  assign host_elig_s = host_req & ~host_gnt;

`ifdef K2_ARB_ROUND_ROBIN_EN
  assign prefer_core_s = last_host_r;
`else
  assign prefer_core_s = 1'b1;
`endif

  assign state_next_s = next_state_f(core_elig_s, host_elig_s, prefer_core_s);

  // Steer the RAM port to the current owner; drive zeros when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    case (state_r)
      G_CORE: begin
        mem_we    = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      G_HOST: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      IDLE: begin
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
      end
    endcase
  end

  // Arbiter FSM: advance the grant state, capture read data and pulse rvalid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      core_rvalid_r <= 1'b0;
      host_rvalid_r <= 1'b0;
      core_rdata_r  <= {DW{1'b0}};
      host_rdata_r  <= {DW{1'b0}};
`ifdef K2_ARB_ROUND_ROBIN_EN
      last_host_r   <= 1'b1;
`endif
    end else begin
      state_r       <= state_next_s;
      core_rvalid_r <= core_gnt & ~core_we;
      host_rvalid_r <= host_gnt & ~host_we;
      if (core_gnt && !core_we) begin
        core_rdata_r <= mem_rdata;
      end
      if (host_gnt && !host_we) begin
        host_rdata_r <= mem_rdata;
      end
`ifdef K2_ARB_ROUND_ROBIN_EN
      if (state_next_s == G_CORE) begin
        last_host_r <= 1'b0;
      end else if (state_next_s == G_HOST) begin
        last_host_r <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_k2_mem_arbiter.sv
// Self-checking bench for k2_mem_arbiter: directed scenarios plus a randomized
// run that is checked against a transaction-level model of the arbiter and a
// shadow copy of the RAM contents.
module tb_k2_mem_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
`ifdef K2_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk, reset_n;
  logic core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] ram [16];
  logic [DW-1:0] model_mem [16];
  int n_vec, n_err;

  k2_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: combinational read, write at the clock edge.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    core_req = r; core_we = w; core_addr = a; core_wdata = d;
  endtask

  task automatic drive_host(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    host_req = r; host_we = w; host_addr = a; host_wdata = d;
  endtask

  task automatic ram_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    model_mem[a] = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    drive_core(1'b0, 1'b0, 4'd0, 8'h00);
    drive_host(1'b0, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) ram_load(AW'(i), DW'($urandom));
    ram_load(4'd3, 8'h5A);
    n_vec++;
    if ({busy, core_gnt, host_gnt, core_rvalid, host_rvalid, mem_we} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got busy/cg/hg/crv/hrv/we=%b want 000000",
               {busy, core_gnt, host_gnt, core_rvalid, host_rvalid, mem_we});
    end
    n_vec++;
    if (core_rdata !== 8'h00 || host_rdata !== 8'h00 || mem_addr !== 4'd0) begin
      n_err++;
      $display("FAIL reset_data: got crd=%h hrd=%h maddr=%h want 00 00 0",
               core_rdata, host_rdata, mem_addr);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_core_read();
    drive_core(1'b1, 1'b0, 4'd3, 8'hFF);
    tick();
    n_vec++;
    if (core_gnt !== 1'b1 || host_gnt !== 1'b0 || mem_addr !== 4'd3 || mem_we !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL core_read_gnt: got cg=%b hg=%b addr=%h we=%b busy=%b want 1 0 3 0 1",
               core_gnt, host_gnt, mem_addr, mem_we, busy);
    end
    drive_core(1'b0, 1'b0, 4'd3, 8'hFF);
    tick();
    n_vec++;
    if (core_rvalid !== 1'b1 || core_rdata !== 8'h5A || core_gnt !== 1'b0 || host_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL core_read_rvalid: got rv=%b rd=%h cg=%b hg=%b want 1 5a 0 0",
               core_rvalid, core_rdata, core_gnt, host_gnt);
    end
    tick();
    n_vec++;
    if (core_rvalid !== 1'b0 || core_rdata !== 8'h5A || busy !== 1'b0 || host_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL core_read_hold: got rv=%b rd=%h busy=%b hg=%b want 0 5a 0 0",
               core_rvalid, core_rdata, busy, host_gnt);
    end
  endtask

  task automatic test_host_write();
    drive_host(1'b1, 1'b1, 4'd7, 8'hC3);
    tick();
    n_vec++;
    if (host_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd7 || mem_wdata !== 8'hC3) begin
      n_err++;
      $display("FAIL host_write_gnt: got hg=%b we=%b addr=%h wd=%h want 1 1 7 c3",
               host_gnt, mem_we, mem_addr, mem_wdata);
    end
    drive_host(1'b0, 1'b1, 4'd7, 8'hC3);
    model_mem[7] = 8'hC3;
    tick();
    n_vec++;
    if (host_rvalid !== 1'b0 || mem_we !== 1'b0 || host_gnt !== 1'b0 || host_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL host_write_after: got hrv=%b we=%b hg=%b hrd=%h want 0 0 0 00",
               host_rvalid, mem_we, host_gnt, host_rdata);
    end
    drive_host(1'b0, 1'b0, 4'd0, 8'h00);
    drive_core(1'b1, 1'b0, 4'd7, 8'h00);
    tick();
    drive_core(1'b0, 1'b0, 4'd7, 8'h00);
    tick();
    n_vec++;
    if (core_rvalid !== 1'b1 || core_rdata !== 8'hC3 || host_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL write_readback: got crv=%b crd=%h hrv=%b want 1 c3 0",
               core_rvalid, core_rdata, host_rvalid);
    end
  endtask

  task automatic test_back_to_back();
    ram_load(4'd1, 8'h11);
    ram_load(4'd2, 8'h22);
    drive_core(1'b1, 1'b0, 4'd1, 8'h00);
    drive_host(1'b1, 1'b0, 4'd2, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (core_gnt !== (i % 2 == 1) || host_gnt !== (i % 2 == 0) || mem_we !== 1'b0 ||
          core_rvalid !== (i % 2 == 0) || host_rvalid !== (i >= 3 && i % 2 == 1) ||
          mem_addr !== ((i % 2 == 1) ? 4'd1 : 4'd2)) begin
        n_err++;
        $display("FAIL b2b cyc%0d: got cg=%b hg=%b we=%b crv=%b hrv=%b addr=%h", i,
                 core_gnt, host_gnt, mem_we, core_rvalid, host_rvalid, mem_addr);
      end
    end
    drive_core(1'b0, 1'b0, 4'd1, 8'h00);
    drive_host(1'b0, 1'b0, 4'd2, 8'h00);
    tick();
    n_vec++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h22 || core_rdata !== 8'h11 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got hrv=%b hrd=%h crd=%h busy=%b want 1 22 11 0",
               host_rvalid, host_rdata, core_rdata, busy);
    end
  endtask

  task automatic test_tie_break();
    drive_host(1'b1, 1'b0, 4'd2, 8'h00);
    tick();
    n_vec++;
    if (host_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL tie_host_only: got hg=%b want 1", host_gnt);
    end
    drive_host(1'b0, 1'b0, 4'd2, 8'h00);
    tick();
    drive_core(1'b1, 1'b0, 4'd1, 8'h00);
    drive_host(1'b1, 1'b0, 4'd2, 8'h00);
    tick();
    n_vec++;
    if (core_gnt !== 1'b1 || host_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL tie_after_host: got cg=%b hg=%b want 1 0", core_gnt, host_gnt);
    end
    drive_core(1'b0, 1'b0, 4'd1, 8'h00);
    drive_host(1'b0, 1'b0, 4'd2, 8'h00);
    tick();
    tick();
    drive_core(1'b1, 1'b0, 4'd1, 8'h00);
    tick();
    n_vec++;
    if (core_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL tie_core_only: got cg=%b want 1", core_gnt);
    end
    drive_core(1'b0, 1'b0, 4'd1, 8'h00);
    tick();
    drive_core(1'b1, 1'b0, 4'd1, 8'h00);
    drive_host(1'b1, 1'b0, 4'd2, 8'h00);
    tick();
    n_vec++;
    if (core_gnt !== !RR || host_gnt !== RR) begin
      n_err++;
      $display("FAIL tie_after_core: got cg=%b hg=%b want %b %b", core_gnt, host_gnt, !RR, RR);
    end
    drive_core(1'b0, 1'b0, 4'd1, 8'h00);
    drive_host(1'b0, 1'b0, 4'd2, 8'h00);
    tick();
    tick();
  endtask

  task automatic test_reset_midgrant();
    drive_core(1'b1, 1'b0, 4'd5, 8'h00);
    tick();
    n_vec++;
    if (core_gnt !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_gnt: got cg=%b busy=%b want 1 1", core_gnt, busy);
    end
    reset_n = 1'b0;
    drive_core(1'b0, 1'b0, 4'd5, 8'h00);
    tick();
    n_vec++;
    if (core_gnt !== 1'b0 || core_rvalid !== 1'b0 || core_rdata !== 8'h00 || busy !== 1'b0 ||
        mem_we !== 1'b0 || host_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL midreset_clear: got cg=%b crv=%b crd=%h busy=%b we=%b hrd=%h",
               core_gnt, core_rvalid, core_rdata, busy, mem_we, host_rdata);
    end
    reset_n = 1'b1;
    tick();
    n_vec++;
    if (core_rvalid !== 1'b0 || core_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_after: got crv=%b cg=%b want 0 0", core_rvalid, core_gnt);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      drive_core(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      drive_host(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      tick();
      n_vec++;
      if (mem_we !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 8'h00 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle cyc%0d: got we=%b addr=%h wd=%h busy=%b want 0 0 00 0",
                 i, mem_we, mem_addr, mem_wdata, busy);
      end
    end
  endtask

  task automatic test_random();
    logic cg, hg, crv, hrv, ncg, nhg, ce, he, last_host, cpend, hpend;
    logic exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] crd, hrd, exp_wd;
    cg = 1'b0; hg = 1'b0; crv = 1'b0; hrv = 1'b0;
    crd = 8'h00; hrd = 8'h00; last_host = 1'b1; cpend = 1'b0; hpend = 1'b0;
    drive_core(1'b0, 1'b0, 4'd0, 8'h00);
    drive_host(1'b0, 1'b0, 4'd0, 8'h00);
    for (int cyc = 0; cyc < 800; cyc++) begin
      // Predict the outcome of the coming edge from the applied requests.
      ce = core_req && !cg;
      he = host_req && !hg;
      ncg = 1'b0; nhg = 1'b0;
      if (ce && he) begin
        if (!RR || last_host) ncg = 1'b1;
        else nhg = 1'b1;
      end else if (ce) ncg = 1'b1;
      else if (he) nhg = 1'b1;
      if (ncg) last_host = 1'b0;
      if (nhg) last_host = 1'b1;
      crv = cg && !core_we;
      hrv = hg && !host_we;
      if (crv) crd = model_mem[core_addr];
      if (hrv) hrd = model_mem[host_addr];
      if (cg && core_we) model_mem[core_addr] = core_wdata;
      if (hg && host_we) model_mem[host_addr] = host_wdata;
      cg = ncg; hg = nhg;
      tick();
      exp_we = cg ? core_we : (hg ? host_we : 1'b0);
      exp_addr = cg ? core_addr : (hg ? host_addr : 4'd0);
      exp_wd = cg ? core_wdata : (hg ? host_wdata : 8'h00);
      n_vec++;
      if (core_gnt !== cg || host_gnt !== hg || busy !== (cg | hg)) begin
        n_err++;
        $display("FAIL rand_gnt cyc%0d: got cg=%b hg=%b busy=%b want %b %b %b",
                 cyc, core_gnt, host_gnt, busy, cg, hg, cg | hg);
      end
      n_vec++;
      if (core_rvalid !== crv || host_rvalid !== hrv) begin
        n_err++;
        $display("FAIL rand_rvalid cyc%0d: got crv=%b hrv=%b want %b %b",
                 cyc, core_rvalid, host_rvalid, crv, hrv);
      end
      n_vec++;
      if (core_rdata !== crd || host_rdata !== hrd) begin
        n_err++;
        $display("FAIL rand_rdata cyc%0d: got crd=%h hrd=%h want %h %h",
                 cyc, core_rdata, host_rdata, crd, hrd);
      end
      n_vec++;
      if (mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wd) begin
        n_err++;
        $display("FAIL rand_mem cyc%0d: got we=%b addr=%h wd=%h want %b %h %h",
                 cyc, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wd);
      end
      // Requesters: hold command through the grant cycle, then move on.
      if (cg) cpend = 1'b0;
      else if (cpend) begin
        if ($urandom_range(0, 15) == 0) begin core_req = 1'b0; cpend = 1'b0; end
      end else if ($urandom_range(0, 3) != 0) begin
        drive_core(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        cpend = 1'b1;
      end else begin
        drive_core(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
      if (hg) hpend = 1'b0;
      else if (hpend) begin
        if ($urandom_range(0, 15) == 0) begin host_req = 1'b0; hpend = 1'b0; end
      end else if ($urandom_range(0, 3) != 0) begin
        drive_host(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        hpend = 1'b1;
      end else begin
        drive_host(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_core_read();
    test_host_write();
    test_back_to_back();
    test_tie_break();
    test_reset_midgrant();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
